pll_reconfig_sequencer: RTL and testbench
=========================================

Name: pll_reconfig_sequencer

Overview:
Parametrised Avalon-MM master that drives a PLL reconfiguration block's management port when the video mode changes. It captures M, N and NUM_C C-counter settings and writes them in a fixed register sequence. It then starts reconfiguration and polls status with a timeout. It sits between the mode/timing selector and the PLL reconfig IP, and adds waitrequest support, pending-request queueing and busy/done/error reporting.

Parameters:
NUM_C, 1, number of C output counters written per reconfiguration (1..18)
WRITE_GAP, 3, cycles per write slot measured from write acceptance to the next slot's strobe (min 2)
TIMEOUT, 4096, maximum status-poll cycles before error
BW_SETTING, 6, data written to the bandwidth register
CP_SETTING, 3, data written to the charge-pump register

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mode_change  in  1  asynchronous request level; each rising edge requests a reconfiguration
cfg_m  in  18  M counter word: {bypass, odd, high[7:0], low[7:0]}
cfg_n  in  18  N counter word, same format
cfg_c  in  18*NUM_C  C counter words; counter i occupies bits [18*i+17:18*i]
mgmt_readdata  in  32  reconfig read data
mgmt_waitrequest  in  1  reconfig slave stall
mgmt_read  out  1  read strobe
mgmt_write  out  1  write strobe
mgmt_address  out  6  register address
mgmt_writedata  out  32  write data
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when lock/status is confirmed
error  out  1  status-poll timeout; sticky until the next sequence starts

Behaviour:
- Reset (async, reset_n low): all outputs 0, state IDLE, pending flag 0, sync flops 0, all counters 0.
- mode_change passes through a 2-flop synchroniser plus an edge-detect flop. A rising edge is detected 3 cycles after the input edge.
- IDLE: on a detected edge or pending=1:
  - latch cfg_m, cfg_n, cfg_c into shadow registers;
  - clear pending and error;
  - set busy;
  - go to WRITE with slot index 0.
  Inputs may change freely after latching.
- Write slot list, in order:
  - 0: addr 0x00, data 1 (polling mode)
  - 1: addr 0x04, data {14'h0, M}
  - 2: addr 0x03, data {14'h0, N}
  - 3..3+NUM_C-1: addr 0x05, data {9'h0, i[4:0], C_i}
  - next: addr 0x08, data BW_SETTING
  - next: addr 0x09, data CP_SETTING
  - last: addr 0x02, data 1 (start)
  - Total slots = NUM_C + 6.
- Each slot:
  - address and writedata become valid in the same cycle mgmt_write rises;
  - mgmt_write is held high while mgmt_waitrequest is 1;
  - the write is accepted on the first cycle with write=1 and waitrequest=0;
  - mgmt_write deasserts the next cycle;
  - WRITE_GAP-1 idle cycles follow, then the next slot starts.
  - With waitrequest tied 0, strobes are exactly WRITE_GAP cycles apart.
- After the start slot's gap: state POLL, address 0x01, mgmt_read=1 held continuously.
- POLL:
  - read data is sampled on cycles where read=1 and waitrequest=0;
  - if readdata[0]=1: read drops next cycle, done pulses 1 cycle, busy clears, state returns to IDLE;
  - a poll counter increments every POLL cycle; on reaching TIMEOUT, read drops, error=1, busy clears, state returns to IDLE, and no done pulse is issued.
- Edge detected while busy: pending is set (multiple edges collapse to one). The new sequence begins the cycle after returning to IDLE and uses the cfg values present at that cycle.
- Edge in the same cycle busy clears: treated as pending, so no request is lost.
- mgmt_address and mgmt_writedata hold their last value when idle.
- mgmt_read and mgmt_write are never high together.

Test Plan:
- NUM_C=1, waitrequest=0, cfg_m=18'h02525, cfg_n=18'h20302, cfg_c=18'h20302, pulse mode_change; status returns 1 on the 2nd read -> 7 writes at addrs 0,4,3,5,8,9,2 with data 1,0x2525,0x20302,0x20302,6,3,1, strobes 3 cycles apart, then a single done pulse with busy low the same cycle.
- NUM_C=3, cfg_c = {18'h00101, 18'h00202, 18'h00303} -> addr 0x05 written 3 times with data 0x00303, 0x40202, 0x80101 in that order.
- Hold waitrequest=1 for 4 cycles during slot 1 -> mgmt_write stays high for 5 cycles with address/data stable, and later slot spacing is unchanged.
- Status bit held 0, TIMEOUT=16 -> read drops after 16 poll cycles, error=1, no done; the next mode_change clears error.
- Two mode_change edges during slot 2 -> exactly one extra full sequence after done, using the updated cfg_m.
- Assert reset_n low mid-POLL -> all outputs 0 immediately, pending cleared, and no activity until a new edge.

Source files
------------

// File: rtl/pll_reconfig_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | pll_reconfig_sequencer                                                     |
// | Writes M/N/C/bandwidth/charge-pump settings to a PLL reconfig port on each |
// | mode change, starts reconfiguration, then polls status with a timeout.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pll_reconfig_sequencer #(
  parameter int unsigned NUM_C      = 1,
  parameter int unsigned WRITE_GAP  = 3,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned BW_SETTING = 6,
  parameter int unsigned CP_SETTING = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mode_change,
  input  logic [17:0]           cfg_m,
  input  logic [17:0]           cfg_n,
  input  logic [18*NUM_C-1:0]   cfg_c,
  input  logic [31:0]           mgmt_readdata,
  input  logic                  mgmt_waitrequest,
  output logic                  mgmt_read,
  output logic                  mgmt_write,
  output logic [5:0]            mgmt_address,
  output logic [31:0]           mgmt_writedata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned GW = $clog2(WRITE_GAP + 1);
  localparam int unsigned PW = $clog2(TIMEOUT + 1);

  localparam logic [4:0]    LAST_SLOT = 5'(NUM_C + 5);
  localparam logic [4:0]    BW_SLOT   = 5'(NUM_C + 3);
  localparam logic [4:0]    CP_SLOT   = 5'(NUM_C + 4);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(WRITE_GAP - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_POLL  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [2:0]          sync_q, sync_d;
  logic                pending_q, pending_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [5:0]          addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [17:0]         m_q, m_d;
  logic [17:0]         n_q, n_d;
  logic [18*NUM_C-1:0] c_q, c_d;
  logic [4:0]          slot_q, slot_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [PW-1:0]       poll_q, poll_d;

  logic                mc_rise;
  logic [4:0]          nxt_slot;
  logic [5:0]          slot_addr;
  logic [31:0]         slot_data;
  logic                unused_rdata;

  assign mc_rise      = sync_q[1] & ~sync_q[2];
  assign nxt_slot     = slot_q + 5'd1;
  assign unused_rdata = ^mgmt_readdata[31:1];

  // Register map for the slot about to be issued; slot 0 is loaded directly from IDLE.
  always_comb begin
    slot_addr = 6'h02;
    slot_data = 32'd1;
    if (nxt_slot == 5'd1) begin
      slot_addr = 6'h04;
      slot_data = {14'h0, m_q};
    end else if (nxt_slot == 5'd2) begin
      slot_addr = 6'h03;
      slot_data = {14'h0, n_q};
    end else if (nxt_slot == BW_SLOT) begin
      slot_addr = 6'h08;
      slot_data = 32'(BW_SETTING);
    end else if (nxt_slot == CP_SLOT) begin
      slot_addr = 6'h09;
      slot_data = 32'(CP_SETTING);
    end
    for (int k = 0; k < int'(NUM_C); k++) begin
      if (nxt_slot == 5'(k + 3)) begin
        slot_addr = 6'h05;
        slot_data = {9'h0, 5'(k), c_q[18*k +: 18]};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[1:0], mode_change};
    pending_d = pending_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    read_d    = read_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    m_d       = m_q;
    n_d       = n_q;
    c_d       = c_q;
    slot_d    = slot_q;
    gap_d     = gap_q;
    poll_d    = poll_q;

    case (state_q)
      ST_IDLE: begin
        if (mc_rise || pending_q) begin
          m_d       = cfg_m;
          n_d       = cfg_n;
          c_d       = cfg_c;
          pending_d = 1'b0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          slot_d    = 5'd0;
          write_d   = 1'b1;
          addr_d    = 6'h00;
          wdata_d   = 32'd1;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!mgmt_waitrequest) begin
          write_d = 1'b0;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(1)) begin
          if (slot_q == LAST_SLOT) begin
            read_d  = 1'b1;
            addr_d  = 6'h01;
            poll_d  = '0;
            state_d = ST_POLL;
          end else begin
            slot_d  = nxt_slot;
            write_d = 1'b1;
            addr_d  = slot_addr;
            wdata_d = slot_data;
            state_d = ST_WRITE;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        poll_d = poll_q + PW'(1);
        // A successful status read wins over a timeout landing on the same cycle.
        if (!mgmt_waitrequest && mgmt_readdata[0]) begin
          read_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (poll_q == POLL_LAST) begin
          read_d  = 1'b0;
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase

    if (mc_rise && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sync_q    <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m_q       <= '0;
      n_q       <= '0;
      c_q       <= '0;
      slot_q    <= '0;
      gap_q     <= '0;
      poll_q    <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      read_q    <= read_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      m_q       <= m_d;
      n_q       <= n_d;
      c_q       <= c_d;
      slot_q    <= slot_d;
      gap_q     <= gap_d;
      poll_q    <= poll_d;
    end
  end

  assign mgmt_read      = read_q;
  assign mgmt_write     = write_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pll_reconfig_sequencer                                                  |
// | Scoreboarded bench: expected register writes queued per sequence.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pll_reconfig_sequencer;

  localparam int NC  = 3;
  localparam int GAP = 3;
  localparam int TO  = 16;

  typedef struct {
    logic [17:0]      m;
    logic [17:0]      n;
    logic [18*NC-1:0] c;
    int               ok;
    bit               err;
  } rec_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              mode_change = 1'b0;
  logic [17:0]       cfg_m = '0;
  logic [17:0]       cfg_n = '0;
  logic [18*NC-1:0]  cfg_c = '0;
  logic [31:0]       mgmt_readdata = '0;
  logic              mgmt_waitrequest = 1'b0;
  logic              mgmt_read, mgmt_write;
  logic [5:0]        mgmt_address;
  logic [31:0]       mgmt_writedata;
  logic              busy, done, error;

  pll_reconfig_sequencer #(
    .NUM_C(NC), .WRITE_GAP(GAP), .TIMEOUT(TO), .BW_SETTING(6), .CP_SETTING(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mode_change(mode_change),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_c(cfg_c),
    .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
    .mgmt_read(mgmt_read), .mgmt_write(mgmt_write),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [37:0] exp_q[$];

  int ok_on = 0;
  int stall_req = 0;
  int stall_used = 0;
  int read_cnt = 0;
  int done_cnt = 0;
  int write_cnt = 0;
  int run_len = 0;
  int last_run4 = 0;
  int read_run = 0;
  int last_read_run = 0;
  int acc_cyc = 0;
  int poll_exp_cyc = 0;
  bit have_acc = 0;
  bit poll_exp = 0;
  bit prev_write = 0;
  bit prev_read = 0;
  logic [5:0]  prev_addr = '0;
  logic [31:0] prev_data = '0;

  // Slave responder first (decides this cycle's waitrequest/readdata), then monitor.
  always @(negedge clk) begin
    logic [37:0] e;
    if (mgmt_write && mgmt_address == 6'h04 && stall_used < stall_req) begin
      mgmt_waitrequest = 1'b1;
      stall_used++;
    end else begin
      mgmt_waitrequest = 1'b0;
    end
    if (!mgmt_write) stall_used = 0;
    if (mgmt_read && !mgmt_waitrequest) begin
      read_cnt++;
      mgmt_readdata = {31'($urandom), (ok_on != 0 && read_cnt >= ok_on)};
    end else if (!mgmt_read) begin
      read_cnt = 0;
      mgmt_readdata = '0;
    end

    if (!reset_n) begin
      have_acc = 0;
      poll_exp = 0;
    end else begin
      if (mgmt_write || mgmt_read) chk("rw_exclusive", mgmt_write & mgmt_read, 0);
      if (mgmt_write && !prev_write) begin
        write_cnt++;
        run_len = 0;
        if (have_acc) chk("strobe_gap", cyc - acc_cyc, GAP);
      end
      if (mgmt_write && prev_write) begin
        chk("hold_addr", mgmt_address, prev_addr);
        chk("hold_data", mgmt_writedata, prev_data);
      end
      if (mgmt_write) run_len++;
      if (mgmt_write && !mgmt_waitrequest) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", mgmt_address, mgmt_writedata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mgmt_address, e[37:32]);
          chk("wr_data", mgmt_writedata, e[31:0]);
        end
        if (mgmt_address == 6'h04) last_run4 = run_len;
        if (mgmt_address == 6'h02) begin
          have_acc = 0;
          poll_exp = 1;
          poll_exp_cyc = cyc + GAP;
        end else begin
          have_acc = 1;
          acc_cyc = cyc;
        end
      end
      if (mgmt_read && !prev_read) begin
        read_run = 0;
        if (poll_exp) chk("poll_start", cyc, poll_exp_cyc);
        poll_exp = 0;
      end
      if (mgmt_read) read_run++;
      if (!mgmt_read && prev_read) last_read_run = read_run;
      if (done) begin
        done_cnt++;
        chk("done_busy_low", busy, 0);
      end
    end
    prev_write = mgmt_write;
    prev_read  = mgmt_read;
    prev_addr  = mgmt_address;
    prev_data  = mgmt_writedata;
  end

  task automatic push_seq(input logic [17:0] m, input logic [17:0] n, input logic [18*NC-1:0] c);
    exp_q.push_back({6'h00, 32'd1});
    exp_q.push_back({6'h04, 14'h0, m});
    exp_q.push_back({6'h03, 14'h0, n});
    for (int i = 0; i < NC; i++) exp_q.push_back({6'h05, 9'h0, 5'(i), c[18*i +: 18]});
    exp_q.push_back({6'h08, 32'd6});
    exp_q.push_back({6'h09, 32'd3});
    exp_q.push_back({6'h02, 32'd1});
  endtask

  task automatic pulse_mode();
    @(posedge clk); #1 mode_change = 1'b1;
    repeat (2) @(posedge clk);
    #1 mode_change = 1'b0;
  endtask

  task automatic wait_idle(input int target);
    bit started = 0;
    bit fin = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #6;
      if (busy && !started) begin
        started = 1;
        chk("err_clr_on_start", error, 0);
      end
      if (started && !busy && (done_cnt >= target || error)) begin
        fin = 1;
        break;
      end
    end
    if (!fin) chk("seq_timeout", 0, 1);
  endtask

  task automatic run_rec(input rec_t r);
    int d0 = done_cnt;
    ok_on = r.ok;
    cfg_m = r.m;
    cfg_n = r.n;
    cfg_c = r.c;
    push_seq(r.m, r.n, r.c);
    pulse_mode();
    wait_idle(d0 + (r.err ? 0 : 1));
    repeat (2) @(negedge clk);
    #1;
    chk("done_count", done_cnt - d0, r.err ? 1'b0 : 1'b1);
    chk("error_flag", error, r.err);
    chk("busy_idle", busy, 0);
    chk("read_low", mgmt_read, 0);
    chk("queue_empty", exp_q.size(), 0);
    chk("addr_hold", mgmt_address, 6'h01);
    chk("wdata_hold", mgmt_writedata, 32'd1);
    if (r.err) chk("timeout_cycles", last_read_run, TO);
    else       chk("poll_reads", last_read_run, r.ok);
  endtask

  rec_t tbl[4];

  initial begin
    int d0;
    int w0;
    bit seen;
    tbl[0] = '{m: 18'h02525, n: 18'h20302, c: {18'h00101, 18'h00202, 18'h00303}, ok: 2, err: 0};
    tbl[1] = '{m: 18'h3FFFF, n: 18'h00000, c: {18'h1A5A5, 18'h25A5A, 18'h3C3C3}, ok: 5, err: 0};
    tbl[2] = '{m: 18'h00102, n: 18'h00201, c: {18'h00404, 18'h00505, 18'h00606}, ok: 0, err: 1};
    tbl[3] = '{m: 18'h10808, n: 18'h30101, c: {18'h00707, 18'h00808, 18'h00909}, ok: 1, err: 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", mgmt_write, 0);
    chk("rst_read", mgmt_read, 0);
    chk("rst_addr", mgmt_address, 0);
    chk("rst_wdata", mgmt_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("post_rst_busy", busy, 0);

    for (int r = 0; r < 4; r++) run_rec(tbl[r]);

    // waitrequest held for 4 cycles on the M-counter write
    stall_req = 4;
    run_rec(tbl[0]);
    chk("stall_write_len", last_run4, 5);
    stall_req = 0;

    // two edges while busy collapse into one extra sequence using the updated M
    d0 = done_cnt;
    w0 = write_cnt;
    ok_on = 2;
    cfg_m = 18'h01111;
    push_seq(18'h01111, cfg_n, cfg_c);
    pulse_mode();
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #6;
      if (mgmt_write && mgmt_address == 6'h03) seen = 1;
    end
    chk("slot2_seen", seen, 1);
    cfg_m = 18'h02222;
    push_seq(18'h02222, cfg_n, cfg_c);
    pulse_mode();
    @(posedge clk); #1;
    pulse_mode();
    wait_idle(d0 + 2);
    repeat (20) @(posedge clk);
    #1;
    chk("dbl_done_count", done_cnt - d0, 2);
    chk("dbl_write_count", write_cnt - w0, 2 * (NC + 6));
    chk("dbl_busy", busy, 0);
    chk("dbl_queue_empty", exp_q.size(), 0);

    // reset during POLL with a pending request outstanding
    ok_on = 0;
    push_seq(cfg_m, cfg_n, cfg_c);
    pulse_mode();
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #6;
      if (mgmt_write && mgmt_address == 6'h05) seen = 1;
    end
    pulse_mode();
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #6;
      if (mgmt_read) seen = 1;
    end
    chk("poll_reached", seen, 1);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_read", mgmt_read, 0);
    chk("arst_write", mgmt_write, 0);
    chk("arst_addr", mgmt_address, 0);
    chk("arst_wdata", mgmt_writedata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_error", error, 0);
    chk("arst_queue_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    w0 = write_cnt;
    repeat (30) @(posedge clk);
    #1;
    chk("no_activity_writes", write_cnt - w0, 0);
    chk("no_activity_busy", busy, 0);

    run_rec(tbl[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
